ped_button_ctrl: RTL and testbench
==================================

# ped_button_ctrl

Pedestrian push-button conditioner and crossing-request controller that sits directly upstream of the traffic-light Counter stage. It synchronises and debounces the raw board button, turns a clean press into a held request, and handshakes that request with the Counter. It then tracks the granted walk phase through the Counter's `state` output and enforces a hold-off before it accepts a new request. Everything runs on the board 50 MHz clock alongside Freq_divider.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles before a button level is accepted (10 ms at 50 MHz); legal range ≥ 1.
- `HOLDOFF_CYCLES`, default 50000000: cycles after walk phase ends during which presses are ignored (1 s); legal range ≥ 1.
- `CNT_W`, default 26: width of the shared debounce/hold-off counter; must hold max(DEBOUNCE_CYCLES, HOLDOFF_CYCLES).
- `WALK_STATE`, default 2'd2: encoding of Counter `state` that denotes the pedestrian walk phase.
- `clk_50MHz` input 1: single clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high; clears every register, including the synchronizer.
- `btn_raw` input 1: asynchronous, bouncy, active-high button.
- `state` input 2: current phase from Counter, synchronous to `clk_50MHz`.
- `ped_ack` input 1: Counter accepts the request; level or pulse.
- `btn_db` output 1: debounced button level.
- `ped_req` output 1: crossing request, held high until acknowledged.
- `req_led` output 1: high while a request is pending or granted but not yet served.
- `press_ignored` output 1: one-cycle pulse when a clean press is discarded.

## Operation
- Synchronizer: two flops, `btn_raw` → `s1` → `s2`; reset value 0.
- Debouncer:
  - Counter `db_cnt` clears whenever `s2 == btn_db`.
  - Otherwise `db_cnt` increments.
  - When `db_cnt` reaches DEBOUNCE_CYCLES−1 while still differing, `btn_db` takes the value of `s2` and `db_cnt` clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes `btn_db`.
- Press event: `btn_db` rising edge, registered copy compared; one cycle wide.
- Request FSM states: IDLE, PENDING, GRANTED, WALK, HOLDOFF; reset → IDLE.
  - IDLE: press → PENDING. `ped_ack` is ignored.
  - PENDING: `ped_ack`=1 → GRANTED. A press here raises `press_ignored`.
  - GRANTED: `state == WALK_STATE` → WALK. A press raises `press_ignored`.
  - WALK: `state != WALK_STATE` → HOLDOFF, loading the hold-off count to 0. A press raises `press_ignored`.
  - HOLDOFF: count increments each cycle; at HOLDOFF_CYCLES−1 → IDLE. A press raises `press_ignored`.
- Outputs:
  - `ped_req` = (FSM == PENDING), registered.
  - `req_led` = (FSM ∈ {PENDING, GRANTED}).
  - `btn_db` and `press_ignored` are registered.
- Hold-off reuses the debounce counter only if that counter is idle. Preferred implementation: a separate `CNT_W` counter.
- Simultaneous events:
  - press and `ped_ack` in IDLE → PENDING, and the ack is dropped.
  - `ped_ack` and press in PENDING → GRANTED with `press_ignored`=1.
- Counters never wrap. Each one clears on state exit and on reset.
- Reset mid-operation: IDLE next edge; all outputs 0; any pending request is lost.

## Timing
- Reset value of every output is 0.
- `btn_raw` rises and is held clean, first sampled at edge 0:
  - `s2`=1 after edge 1.
  - `btn_db`=1 after edge 1+DEBOUNCE_CYCLES.
  - `ped_req`=1 and `req_led`=1 two edges later: press register edge, then FSM edge.
- `ped_ack` sampled high at edge k in PENDING → `ped_req`=0 after edge k+1. `req_led` stays 1.
- `state` enters WALK_STATE at edge j → WALK after edge j+1 and `req_led`=0.
- `state` leaves WALK_STATE at edge m → IDLE after m+1+HOLDOFF_CYCLES.
- `press_ignored` is high for exactly one cycle, two edges after `btn_db` rises.
- Release: `btn_db` falls DEBOUNCE_CYCLES edges after `s2` falls. No FSM effect.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8, WALK_STATE=2.
- Clean press: `btn_raw` 0→1 held 20 cycles → `btn_db`=1 at cycle 5, `ped_req`=1 at cycle 7 and held; `ped_ack` pulse at cycle 12 → `ped_req`=0 at cycle 13, `req_led`=1.
- Bounce: 3-cycle high pulses separated by 2-cycle lows for 30 cycles → `btn_db`, `ped_req` and `press_ignored` stay 0 throughout.
- Full cycle: press, ack, then `state`=2 for 10 cycles, then `state`=0 → `req_led` drops one cycle after `state`=2; IDLE 9 cycles after `state` leaves 2. A press during hold-off gives a `press_ignored` pulse and no `ped_req`.
- Simultaneous: press and `ped_ack` together in IDLE → PENDING, `ped_req`=1; a second press while PENDING → one `press_ignored` pulse and `ped_req` unchanged.
- Reset mid-operation: assert `reset` for 1 cycle while PENDING → next cycle all outputs 0 and FSM is IDLE; `btn_raw` still high → no new press until release, then a fresh 0→1.
- Stray ack: `ped_ack`=1 for 5 cycles in IDLE → no state change and all outputs 0.

Source files
------------

// File: rtl/ped_button_ctrl.sv
// ped_button_ctrl: button sync/debounce and crossing-request FSM.
// Handshakes a held request with Counter and holds off after walk.
module ped_button_ctrl #(
   parameter int         DEBOUNCE_CYCLES = 500000,
   parameter int         HOLDOFF_CYCLES  = 50000000,
   parameter int         CNT_W           = 26,
   parameter logic [1:0] WALK_STATE      = 2'd2
) (
   input  logic       clk_50MHz,
   input  logic       reset,
   input  logic       btn_raw,
   input  logic [1:0] state,
   input  logic       ped_ack,
   output logic       btn_db,
   output logic       ped_req,
   output logic       req_led,
   output logic       press_ignored
);

   typedef enum logic [2:0] {
      IDLE,
      PENDING,
      GRANTED,
      WALK,
      HOLDOFF
   } fsm_t;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HO_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

   logic             s1_q, s2_q;
   logic [1:0]       warm_q;
   logic             arm_q;
   logic [CNT_W-1:0] db_cnt_q;
   logic             btn_db_q, db_prev_q;
   logic             press_q, ack_q;
   fsm_t             fsm_q, fsm_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic             ign_q, ign_d;

   // Two-flop synchronizer; arm only once the button is seen released
   // after reset, so a button held through reset never makes a press.
   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         warm_q <= 2'b00;
         arm_q  <= 1'b0;
      end else begin
         s1_q   <= btn_raw;
         s2_q   <= s1_q;
         warm_q <= {warm_q[0], 1'b1};
         if (warm_q == 2'b11 && !s2_q) begin
            arm_q <= 1'b1;
         end
      end
   end

   // Debouncer: accept a new level after DEBOUNCE_CYCLES stable samples.
   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         db_cnt_q <= '0;
         btn_db_q <= 1'b0;
      end else if (s2_q == btn_db_q) begin
         db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
         db_cnt_q <= '0;
         btn_db_q <= s2_q;
      end else begin
         db_cnt_q <= db_cnt_q + 1'b1;
      end
   end

   // Register the press edge and the ack so the FSM sees them together.
   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         db_prev_q <= 1'b0;
         press_q   <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         db_prev_q <= btn_db_q;
         press_q   <= btn_db_q & ~db_prev_q & arm_q;
         ack_q     <= ped_ack;
      end
   end

   // Request FSM next state, hold-off count and ignored-press pulse.
   always_comb begin
      fsm_d  = fsm_q;
      hold_d = '0;
      ign_d  = 1'b0;
      unique case (fsm_q)
         IDLE: begin
            if (press_q) fsm_d = PENDING;
         end
         PENDING: begin
            ign_d = press_q;
            if (ack_q) fsm_d = GRANTED;
         end
         GRANTED: begin
            ign_d = press_q;
            if (state == WALK_STATE) fsm_d = WALK;
         end
         WALK: begin
            ign_d = press_q;
            if (state != WALK_STATE) fsm_d = HOLDOFF;
         end
         HOLDOFF: begin
            ign_d = press_q;
            if (hold_q == HO_LAST) begin
               fsm_d = IDLE;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   // FSM state, hold-off counter and pulse registers.
   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         fsm_q  <= IDLE;
         hold_q <= '0;
         ign_q  <= 1'b0;
      end else begin
         fsm_q  <= fsm_d;
         hold_q <= hold_d;
         ign_q  <= ign_d;
      end
   end

   assign btn_db        = btn_db_q;
   assign ped_req       = (fsm_q == PENDING);
   assign req_led       = (fsm_q == PENDING) || (fsm_q == GRANTED);
   assign press_ignored = ign_q;

endmodule

// File: tb/tb_ped_button_ctrl.sv
// tb_ped_button_ctrl: directed checks of ped_button_ctrl.
// DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8, WALK_STATE=2.
module tb_ped_button_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_raw;
   logic [1:0] state;
   logic       ped_ack;
   logic       btn_db, ped_req, req_led, press_ignored;
   int         errs = 0;
   int         checks = 0;

   ped_button_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .HOLDOFF_CYCLES (8),
      .CNT_W          (8),
      .WALK_STATE     (2'd2)
   ) dut (
      .clk_50MHz    (clk),
      .reset        (reset),
      .btn_raw      (btn_raw),
      .state        (state),
      .ped_ack      (ped_ack),
      .btn_db       (btn_db),
      .ped_req      (ped_req),
      .req_led      (req_led),
      .press_ignored(press_ignored)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic chk_all0(input string tag);
      chk({tag, "_db"}, btn_db, 1'b0);
      chk({tag, "_req"}, ped_req, 1'b0);
      chk({tag, "_led"}, req_led, 1'b0);
      chk({tag, "_ign"}, press_ignored, 1'b0);
   endtask

   initial begin
      reset   = 1'b1;
      btn_raw = 1'b0;
      state   = 2'd0;
      ped_ack = 1'b0;
      tick(2);
      chk_all0("reset");
      reset = 1'b0;
      tick(6);

      // Bounce: 3 high / 2 low, never long enough to be accepted
      for (int i = 0; i < 30; i++) begin
         btn_raw = ((i % 5) < 3);
         tick();
         chk("bounce_db", btn_db, 1'b0);
         chk("bounce_req", ped_req, 1'b0);
         chk("bounce_ign", press_ignored, 1'b0);
      end
      btn_raw = 1'b0;
      tick(10);

      // Clean press; tick k+1 lands just after edge k
      btn_raw = 1'b1;
      tick(5);
      chk("clean_db_e4", btn_db, 1'b0);
      tick();
      chk("clean_db_e5", btn_db, 1'b1);
      tick();
      chk("clean_req_e6", ped_req, 1'b0);
      tick();
      chk("clean_req_e7", ped_req, 1'b1);
      chk("clean_led_e7", req_led, 1'b1);
      tick(4);
      ped_ack = 1'b1;
      tick();
      ped_ack = 1'b0;
      chk("ack_req_e12", ped_req, 1'b1);
      tick();
      chk("ack_req_e13", ped_req, 1'b0);
      chk("ack_led_e13", req_led, 1'b1);
      tick(3);
      chk("granted_req", ped_req, 1'b0);
      chk("granted_led", req_led, 1'b1);

      // Walk phase, release button during it
      state   = 2'd2;
      btn_raw = 1'b0;
      tick();
      chk("walk_led", req_led, 1'b0);
      chk("walk_req", ped_req, 1'b0);
      tick(9);

      // Leave walk and press during hold-off
      state   = 2'd0;
      btn_raw = 1'b1;
      tick(7);
      chk("ho_ign_pre", press_ignored, 1'b0);
      tick();
      chk("ho_ign", press_ignored, 1'b1);
      chk("ho_req", ped_req, 1'b0);
      tick();
      chk("ho_ign_post", press_ignored, 1'b0);
      chk("ho_req_post", ped_req, 1'b0);
      tick(3);
      chk("ho_req_late", ped_req, 1'b0);

      // Back in IDLE: a fresh press is accepted
      btn_raw = 1'b0;
      tick(8);
      btn_raw = 1'b1;
      tick(7);
      chk("idle_req_e6", ped_req, 1'b0);
      tick();
      chk("idle_req_e7", ped_req, 1'b1);

      // Second press while PENDING
      btn_raw = 1'b0;
      tick(8);
      btn_raw = 1'b1;
      tick(7);
      chk("pend_ign_pre", press_ignored, 1'b0);
      tick();
      chk("pend_ign", press_ignored, 1'b1);
      chk("pend_req", ped_req, 1'b1);
      tick();
      chk("pend_ign_post", press_ignored, 1'b0);
      chk("pend_req_post", ped_req, 1'b1);

      // Reset while PENDING with the button still held
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_all0("midrst");
      tick(15);
      chk("midrst_db_held", btn_db, 1'b1);
      chk("midrst_req_held", ped_req, 1'b0);
      chk("midrst_ign_held", press_ignored, 1'b0);

      // Release, then press and ack together in IDLE
      btn_raw = 1'b0;
      tick(8);
      btn_raw = 1'b1;
      tick(6);
      ped_ack = 1'b1;
      tick();
      ped_ack = 1'b0;
      tick();
      chk("sim_req_e7", ped_req, 1'b1);
      tick();
      chk("sim_req_e8", ped_req, 1'b1);
      tick(4);
      chk("sim_req_late", ped_req, 1'b1);
      chk("sim_led_late", req_led, 1'b1);

      // Stray ack in IDLE
      reset   = 1'b1;
      btn_raw = 1'b0;
      tick();
      reset = 1'b0;
      tick(6);
      ped_ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stray_req", ped_req, 1'b0);
         chk("stray_led", req_led, 1'b0);
      end
      ped_ack = 1'b0;
      tick(3);
      chk_all0("stray_end");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
